// File: rtl/prog_counter.sv
// ============================================================================
// prog_counter : up/down modulus counter with wrap/saturate boundary handling,
// terminal-count pulse and compare. Optional prescaler: COUNTER_PRESCALE_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  sat,
  input  logic [WIDTH-1:0]      cmp_val,
  input  logic [PRESCALE_W-1:0] prescale_div,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  cmp_match
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             w_tick;
  logic             w_step;
  logic             w_boundary;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_clamped;

`ifdef COUNTER_PRESCALE_EN
  localparam logic [PRESCALE_W-1:0] C_DIV_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] r_div;

  assign w_tick = (r_div == prescale_div);

  // Divider only advances on enabled cycles and restarts whenever count is forced.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || load) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= w_tick ? '0 : (r_div + C_DIV_ONE);
    end
  end
`else
  logic w_unused_prescale;

  assign w_tick            = 1'b1;
  assign w_unused_prescale = ^prescale_div;
`endif

  assign w_step         = en & w_tick;
  assign w_load_clamped = (load_val > limit) ? limit : load_val;

  always_comb begin
    w_boundary = 1'b0;
    w_next     = r_count;
    if (up) begin
      // count >= limit also covers a limit lowered below the current count
      if (r_count >= limit) begin
        w_boundary = 1'b1;
        w_next     = sat ? limit : '0;
      end else begin
        w_next = r_count + C_ONE;
      end
    end else begin
      if (r_count == '0) begin
        w_boundary = 1'b1;
        w_next     = sat ? '0 : limit;
      end else if (r_count > limit) begin
        w_next = limit;
      end else begin
        w_next = r_count - C_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      r_count <= w_next;
      r_tc    <= w_boundary;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  assign count     = r_count;
  assign tc        = r_tc;
  assign cmp_match = (r_count == cmp_val);

endmodule

`default_nettype wire
